id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width of operands, PC and immediate.
REQ-002 SHALL have parameter CNT_W, default 16, width of bubble counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on rising clk edge.
REQ-005 id_valid  input  1  ID slot holds a real instruction.
REQ-006 id_pc, id_imm  input  DATA_W each  PC and sign-extended immediate from decode.
REQ-007 id_rs, id_rt, id_rd  input  5 each  source/destination register numbers.
REQ-008 id_rdata1, id_rdata2  input  DATA_W each  register-file read data for rs, rt.
REQ-009 id_regWrite, id_memRead, id_memWrite, id_aluSrc, id_regDst  input  1 each  decoded control.
REQ-010 id_aluOp  input  3  ALU operation code.
REQ-011 wb_write, wb_addr[4:0], wb_data[DATA_W]  input  same write-back signals driven into the register file.
REQ-012 flush  input  1  squash the instruction entering EX (taken branch/jump).
REQ-013 stall  output  1  combinational; holds PC and IF/ID this cycle.
REQ-014 ex_valid, ex_regWrite, ex_memRead, ex_memWrite, ex_aluSrc  output  1 each  registered.
REQ-015 ex_aluOp[3], ex_pc, ex_imm, ex_a, ex_b [DATA_W], ex_rs, ex_rt, ex_dst [5]  output  registered.
REQ-016 bubble_cnt  output  CNT_W  registered count of bubbles inserted.

Function
REQ-017 hazard SHALL be ex_valid & ex_memRead & (ex_rt != 0) & id_valid & (id_rs == ex_rt | id_rt == ex_rt).
REQ-018 stall SHALL equal hazard & ~flush; no registered delay.
REQ-019 Each rising edge with rst_n=1 SHALL select exactly one action, priority: flush, then hazard, then load.
REQ-020 flush or hazard SHALL insert bubble: ex_valid, ex_regWrite, ex_memRead, ex_memWrite cleared to 0; all other ex_* outputs cleared to 0.
REQ-021 load SHALL capture id_* into ex_*; ex_valid <= id_valid; when id_valid=0, the four control bits in REQ-020 SHALL be written 0 regardless of id_* values.
REQ-022 ex_dst SHALL be id_rd when id_regDst=1, else id_rt; ex_rs/ex_rt SHALL be id_rs/id_rt.
REQ-023 WB bypass: ex_a <= wb_data when wb_write & wb_addr!=0 & wb_addr==id_rs, else id_rdata1.
REQ-024 WB bypass: ex_b <= wb_data when wb_write & wb_addr!=0 & wb_addr==id_rt, else id_rdata2; rs and rt both matching SHALL both bypass.
REQ-025 wb_addr=0 SHALL never bypass; register 0 reads as id_rdata (zero).
REQ-026 bubble_cnt SHALL increment by 1 on each edge performing a flush or hazard bubble, saturating at all-ones (no wrap).
REQ-027 id_valid=0 without flush/hazard SHALL NOT increment bubble_cnt.
REQ-028 Latency SHALL be exactly one cycle from ID inputs to ex_* outputs; no internal buffering beyond one stage.

Reset
REQ-029 rst_n=0 at a rising edge SHALL clear every registered output, including bubble_cnt, to 0, overriding flush/hazard/load.
REQ-030 During reset stall SHALL be 0 (follows from ex_valid=0 after first reset edge); reset mid-bubble SHALL leave no pending stall.

Verification
REQ-031 Load: id_valid=1, rs=3, rt=4, rd=5, regDst=1, rdata1=0x11, rdata2=0x22, no wb -> next cycle ex_a=0x11, ex_b=0x22, ex_dst=5, ex_valid=1, stall=0.
REQ-032 Bypass: wb_write=1, wb_addr=3, wb_data=0xABCD, id_rs=id_rt=3, rdata=0x11 -> ex_a=ex_b=0xABCD; repeat with wb_addr=0 -> ex_a=ex_b=0x11.
REQ-033 Load-use: EX holds lw (memRead=1, ex_rt=7, valid); ID has rs=7 -> stall=1 same cycle; next edge ex_valid=0, controls 0, bubble_cnt=1; following cycle stall=0, instruction loads.
REQ-034 Flush priority: hazard and flush both 1 -> stall=0, bubble inserted, bubble_cnt +1 once; ex_rt=0 with memRead -> no hazard.
REQ-035 Saturation/reset: force 2^CNT_W+3 bubbles -> bubble_cnt=0xFFFF (CNT_W=16); assert rst_n=0 with flush=1 -> all outputs 0 next edge.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// ID/EX pipeline-register bundle: decode-side inputs, write-back bypass
// inputs, the branch flush, and everything the stage presents to EX.
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  // Decode slot
  logic              id_valid;
  logic [DATA_W-1:0] id_pc;
  logic [DATA_W-1:0] id_imm;
  logic [4:0]        id_rs;
  logic [4:0]        id_rt;
  logic [4:0]        id_rd;
  logic [DATA_W-1:0] id_rdata1;
  logic [DATA_W-1:0] id_rdata2;
  logic              id_regWrite;
  logic              id_memRead;
  logic              id_memWrite;
  logic              id_aluSrc;
  logic              id_regDst;
  logic [2:0]        id_aluOp;

  // Write-back port as seen by the register file
  logic              wb_write;
  logic [4:0]        wb_addr;
  logic [DATA_W-1:0] wb_data;

  // Taken branch / jump squash
  logic              flush;

  // Stage outputs
  logic              stall;
  logic              ex_valid;
  logic              ex_regWrite;
  logic              ex_memRead;
  logic              ex_memWrite;
  logic              ex_aluSrc;
  logic [2:0]        ex_aluOp;
  logic [DATA_W-1:0] ex_pc;
  logic [DATA_W-1:0] ex_imm;
  logic [DATA_W-1:0] ex_a;
  logic [DATA_W-1:0] ex_b;
  logic [4:0]        ex_rs;
  logic [4:0]        ex_rt;
  logic [4:0]        ex_dst;
  logic [CNT_W-1:0]  bubble_cnt;

  // Surrounding pipeline: drives decode/WB/flush, observes the stage
  modport master (
    output id_valid, id_pc, id_imm, id_rs, id_rt, id_rd,
           id_rdata1, id_rdata2, id_regWrite, id_memRead, id_memWrite,
           id_aluSrc, id_regDst, id_aluOp, wb_write, wb_addr, wb_data, flush,
    input  stall, ex_valid, ex_regWrite, ex_memRead, ex_memWrite, ex_aluSrc,
           ex_aluOp, ex_pc, ex_imm, ex_a, ex_b, ex_rs, ex_rt, ex_dst, bubble_cnt
  );

  // The ID/EX stage itself
  modport slave (
    input  id_valid, id_pc, id_imm, id_rs, id_rt, id_rd,
           id_rdata1, id_rdata2, id_regWrite, id_memRead, id_memWrite,
           id_aluSrc, id_regDst, id_aluOp, wb_write, wb_addr, wb_data, flush,
    output stall, ex_valid, ex_regWrite, ex_memRead, ex_memWrite, ex_aluSrc,
           ex_aluOp, ex_pc, ex_imm, ex_a, ex_b, ex_rs, ex_rt, ex_dst, bubble_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, write-back
// bypass into the operand registers, branch-flush bubbles and a saturating
// count of inserted bubbles. One cycle of latency, no extra buffering.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input logic           clk,
  input logic           rst_n,
  id_ex_stage_if.slave  bus
);

  // Pipeline registers
  logic              r_ex_valid;
  logic              r_ex_reg_write;
  logic              r_ex_mem_read;
  logic              r_ex_mem_write;
  logic              r_ex_alu_src;
  logic [2:0]        r_ex_alu_op;
  logic [DATA_W-1:0] r_ex_pc;
  logic [DATA_W-1:0] r_ex_imm;
  logic [DATA_W-1:0] r_ex_a;
  logic [DATA_W-1:0] r_ex_b;
  logic [4:0]        r_ex_rs;
  logic [4:0]        r_ex_rt;
  logic [4:0]        r_ex_dst;
  logic [CNT_W-1:0]  r_bubble_cnt;

  // Next-state values
  logic              w_nxt_valid;
  logic              w_nxt_reg_write;
  logic              w_nxt_mem_read;
  logic              w_nxt_mem_write;
  logic              w_nxt_alu_src;
  logic [2:0]        w_nxt_alu_op;
  logic [DATA_W-1:0] w_nxt_pc;
  logic [DATA_W-1:0] w_nxt_imm;
  logic [DATA_W-1:0] w_nxt_a;
  logic [DATA_W-1:0] w_nxt_b;
  logic [4:0]        w_nxt_rs;
  logic [4:0]        w_nxt_rt;
  logic [4:0]        w_nxt_dst;
  logic [CNT_W-1:0]  w_nxt_cnt;

  logic              w_hazard;
  logic              w_bubble;
  logic              w_byp_a;
  logic              w_byp_b;
  logic [CNT_W-1:0]  w_cnt_inc;

  // A load in EX whose destination is read by the instruction in ID must
  // wait one cycle; r0 is never a real dependency.
  assign w_hazard = r_ex_valid & r_ex_mem_read & (r_ex_rt != 5'd0) &
                    bus.id_valid &
                    ((bus.id_rs == r_ex_rt) | (bus.id_rt == r_ex_rt));

  // A flush squashes the stalled instruction anyway, so it suppresses stall.
  assign bus.stall = w_hazard & ~bus.flush;
  assign w_bubble  = bus.flush | w_hazard;

  // Register file is written at the same edge it is read, so forward the
  // write-back value; writes to r0 are discarded by the register file.
  assign w_byp_a = bus.wb_write & (bus.wb_addr != 5'd0) & (bus.wb_addr == bus.id_rs);
  assign w_byp_b = bus.wb_write & (bus.wb_addr != 5'd0) & (bus.wb_addr == bus.id_rt);

  // Bubble counter sticks at all-ones instead of wrapping.
  assign w_cnt_inc = (r_bubble_cnt == {CNT_W{1'b1}}) ? r_bubble_cnt
                   : r_bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

  // Choose between bubble insertion and a normal load of the ID slot.
  always_comb begin
    w_nxt_valid     = 1'b0;
    w_nxt_reg_write = 1'b0;
    w_nxt_mem_read  = 1'b0;
    w_nxt_mem_write = 1'b0;
    w_nxt_alu_src   = 1'b0;
    w_nxt_alu_op    = 3'd0;
    w_nxt_pc        = {DATA_W{1'b0}};
    w_nxt_imm       = {DATA_W{1'b0}};
    w_nxt_a         = {DATA_W{1'b0}};
    w_nxt_b         = {DATA_W{1'b0}};
    w_nxt_rs        = 5'd0;
    w_nxt_rt        = 5'd0;
    w_nxt_dst       = 5'd0;
    w_nxt_cnt       = r_bubble_cnt;
    if (w_bubble) begin
      w_nxt_cnt = w_cnt_inc;
    end else begin
      // An empty ID slot must never carry side-effecting controls into EX.
      w_nxt_valid     = bus.id_valid;
      w_nxt_reg_write = bus.id_valid & bus.id_regWrite;
      w_nxt_mem_read  = bus.id_valid & bus.id_memRead;
      w_nxt_mem_write = bus.id_valid & bus.id_memWrite;
      w_nxt_alu_src   = bus.id_aluSrc;
      w_nxt_alu_op    = bus.id_aluOp;
      w_nxt_pc        = bus.id_pc;
      w_nxt_imm       = bus.id_imm;
      w_nxt_a         = w_byp_a ? bus.wb_data : bus.id_rdata1;
      w_nxt_b         = w_byp_b ? bus.wb_data : bus.id_rdata2;
      w_nxt_rs        = bus.id_rs;
      w_nxt_rt        = bus.id_rt;
      w_nxt_dst       = bus.id_regDst ? bus.id_rd : bus.id_rt;
    end
  end

  // Pipeline register update; reset overrides flush, hazard and load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ex_valid     <= 1'b0;
      r_ex_reg_write <= 1'b0;
      r_ex_mem_read  <= 1'b0;
      r_ex_mem_write <= 1'b0;
      r_ex_alu_src   <= 1'b0;
      r_ex_alu_op    <= 3'd0;
      r_ex_pc        <= {DATA_W{1'b0}};
      r_ex_imm       <= {DATA_W{1'b0}};
      r_ex_a         <= {DATA_W{1'b0}};
      r_ex_b         <= {DATA_W{1'b0}};
      r_ex_rs        <= 5'd0;
      r_ex_rt        <= 5'd0;
      r_ex_dst       <= 5'd0;
      r_bubble_cnt   <= {CNT_W{1'b0}};
    end else begin
      r_ex_valid     <= w_nxt_valid;
      r_ex_reg_write <= w_nxt_reg_write;
      r_ex_mem_read  <= w_nxt_mem_read;
      r_ex_mem_write <= w_nxt_mem_write;
      r_ex_alu_src   <= w_nxt_alu_src;
      r_ex_alu_op    <= w_nxt_alu_op;
      r_ex_pc        <= w_nxt_pc;
      r_ex_imm       <= w_nxt_imm;
      r_ex_a         <= w_nxt_a;
      r_ex_b         <= w_nxt_b;
      r_ex_rs        <= w_nxt_rs;
      r_ex_rt        <= w_nxt_rt;
      r_ex_dst       <= w_nxt_dst;
      r_bubble_cnt   <= w_nxt_cnt;
    end
  end

  assign bus.ex_valid    = r_ex_valid;
  assign bus.ex_regWrite = r_ex_reg_write;
  assign bus.ex_memRead  = r_ex_mem_read;
  assign bus.ex_memWrite = r_ex_mem_write;
  assign bus.ex_aluSrc   = r_ex_alu_src;
  assign bus.ex_aluOp    = r_ex_alu_op;
  assign bus.ex_pc       = r_ex_pc;
  assign bus.ex_imm      = r_ex_imm;
  assign bus.ex_a        = r_ex_a;
  assign bus.ex_b        = r_ex_b;
  assign bus.ex_rs       = r_ex_rs;
  assign bus.ex_rt       = r_ex_rt;
  assign bus.ex_dst      = r_ex_dst;
  assign bus.bubble_cnt  = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table, hand-written
// hazard/flush/reset/saturation sequences and random cycles, all compared
// against a reference model of the stage's architectural behaviour.
module tb_id_ex_stage;

  localparam int DW = 32;
  localparam int CW = 16;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  id_ex_stage_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

  id_ex_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference view of what EX should hold
  typedef struct {
    logic          valid, reg_write, mem_read, mem_write, alu_src;
    logic [2:0]    alu_op;
    logic [DW-1:0] pc, imm, a, b;
    logic [4:0]    rs, rt, dst;
    int            cnt;
  } model_t;

  model_t m;

  task automatic clear_model();
    m.valid = 0; m.reg_write = 0; m.mem_read = 0; m.mem_write = 0; m.alu_src = 0;
    m.alu_op = 0; m.pc = 0; m.imm = 0; m.a = 0; m.b = 0;
    m.rs = 0; m.rt = 0; m.dst = 0;
  endtask

  function automatic bit model_hazard();
    return m.valid && m.mem_read && (m.rt != 0) && bus.id_valid &&
           (bus.id_rs == m.rt || bus.id_rt == m.rt);
  endfunction

  // Apply one rising edge to the model
  task automatic model_edge();
    bit hz;
    hz = model_hazard();
    if (!rst_n) begin
      clear_model();
      m.cnt = 0;
    end else if (bus.flush || hz) begin
      clear_model();
      if (m.cnt < 65535) m.cnt = m.cnt + 1;
    end else begin
      m.valid     = bus.id_valid;
      m.reg_write = bus.id_valid ? bus.id_regWrite : 1'b0;
      m.mem_read  = bus.id_valid ? bus.id_memRead  : 1'b0;
      m.mem_write = bus.id_valid ? bus.id_memWrite : 1'b0;
      m.alu_src   = bus.id_aluSrc;
      m.alu_op    = bus.id_aluOp;
      m.pc        = bus.id_pc;
      m.imm       = bus.id_imm;
      m.rs        = bus.id_rs;
      m.rt        = bus.id_rt;
      m.dst       = bus.id_regDst ? bus.id_rd : bus.id_rt;
      m.a = (bus.wb_write && bus.wb_addr != 0 && bus.wb_addr == bus.id_rs) ? bus.wb_data : bus.id_rdata1;
      m.b = (bus.wb_write && bus.wb_addr != 0 && bus.wb_addr == bus.id_rt) ? bus.wb_data : bus.id_rdata2;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("ex_valid",    bus.ex_valid,    m.valid);
    chk("ex_regWrite", bus.ex_regWrite, m.reg_write);
    chk("ex_memRead",  bus.ex_memRead,  m.mem_read);
    chk("ex_memWrite", bus.ex_memWrite, m.mem_write);
    chk("ex_aluSrc",   bus.ex_aluSrc,   m.alu_src);
    chk("ex_aluOp",    bus.ex_aluOp,    m.alu_op);
    chk("ex_pc",       bus.ex_pc,       m.pc);
    chk("ex_imm",      bus.ex_imm,      m.imm);
    chk("ex_a",        bus.ex_a,        m.a);
    chk("ex_b",        bus.ex_b,        m.b);
    chk("ex_rs",       bus.ex_rs,       m.rs);
    chk("ex_rt",       bus.ex_rt,       m.rt);
    chk("ex_dst",      bus.ex_dst,      m.dst);
    chk("bubble_cnt",  bus.bubble_cnt,  m.cnt[CW-1:0]);
  endtask

  // Called just after a negedge with inputs set: check stall, clock, check state
  task automatic cycle();
    #1;
    chk("stall", bus.stall, model_hazard() && !bus.flush);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_inputs();
    bus.id_valid = 0; bus.id_pc = 0; bus.id_imm = 0;
    bus.id_rs = 0; bus.id_rt = 0; bus.id_rd = 0;
    bus.id_rdata1 = 0; bus.id_rdata2 = 0;
    bus.id_regWrite = 0; bus.id_memRead = 0; bus.id_memWrite = 0;
    bus.id_aluSrc = 0; bus.id_regDst = 0; bus.id_aluOp = 0;
    bus.wb_write = 0; bus.wb_addr = 0; bus.wb_data = 0;
    bus.flush = 0;
  endtask

  // Put a load (lw) with destination rt into EX
  task automatic load_lw(input logic [4:0] rt);
    idle_inputs();
    bus.id_valid = 1; bus.id_rs = 5'd1; bus.id_rt = rt; bus.id_rd = 5'd0;
    bus.id_memRead = 1; bus.id_regWrite = 1; bus.id_aluSrc = 1;
    bus.id_imm = 32'h8; bus.id_rdata1 = 32'h1000;
    cycle();
  endtask

  typedef struct {
    logic          valid;
    logic [4:0]    rs, rt, rd;
    logic          reg_dst;
    logic [DW-1:0] rdata1, rdata2;
    logic          wb_write;
    logic [4:0]    wb_addr;
    logic [DW-1:0] wb_data;
    logic [DW-1:0] exp_a, exp_b;
    logic [4:0]    exp_dst;
    logic          exp_valid;
  } vec_t;

  vec_t vecs [7];
  int   c0;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m.cnt    = 0;
    clear_model();

    //          v  rs  rt  rd  rdst rdata1       rdata2       wbw addr wb_data       exp_a        exp_b        dst v
    vecs[0] = '{1, 3,  4,  5,  1, 32'h11,      32'h22,      0, 0,  32'h0,       32'h11,      32'h22,      5,  1};
    vecs[1] = '{1, 3,  3,  9,  0, 32'h11,      32'h11,      1, 3,  32'hABCD,    32'hABCD,    32'hABCD,    3,  1};
    vecs[2] = '{1, 3,  3,  9,  0, 32'h11,      32'h11,      1, 0,  32'hABCD,    32'h11,      32'h11,      3,  1};
    vecs[3] = '{1, 1,  6,  10, 1, 32'hAA,      32'hBB,      1, 6,  32'h55,      32'hAA,      32'h55,      10, 1};
    vecs[4] = '{1, 8,  9,  2,  0, 32'hC0,      32'hD0,      1, 8,  32'h77,      32'h77,      32'hD0,      9,  1};
    vecs[5] = '{0, 2,  5,  7,  1, 32'h1234,    32'h5678,    0, 0,  32'h0,       32'h1234,    32'h5678,    7,  0};
    vecs[6] = '{1, 4,  4,  1,  1, 32'hDEAD,    32'hBEEF,    0, 4,  32'h99,      32'hDEAD,    32'hBEEF,    1,  1};

    // Reset
    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    clear_model();
    m.cnt = 0;
    cycle();
    chk("reset_valid", bus.ex_valid, 1'b0);
    chk("reset_cnt", bus.bubble_cnt, 16'h0);
    rst_n = 1;

    // Directed vector table
    for (int i = 0; i < 7; i++) begin
      idle_inputs();
      bus.id_valid = vecs[i].valid; bus.id_rs = vecs[i].rs; bus.id_rt = vecs[i].rt;
      bus.id_rd = vecs[i].rd; bus.id_regDst = vecs[i].reg_dst;
      bus.id_rdata1 = vecs[i].rdata1; bus.id_rdata2 = vecs[i].rdata2;
      bus.wb_write = vecs[i].wb_write; bus.wb_addr = vecs[i].wb_addr; bus.wb_data = vecs[i].wb_data;
      bus.id_regWrite = 1; bus.id_memWrite = 1; bus.id_aluSrc = 1; bus.id_aluOp = 3'd5;
      bus.id_pc = 32'h100 + 32'(i); bus.id_imm = 32'(i);
      cycle();
      chk("vec_a", bus.ex_a, vecs[i].exp_a);
      chk("vec_b", bus.ex_b, vecs[i].exp_b);
      chk("vec_dst", bus.ex_dst, vecs[i].exp_dst);
      chk("vec_valid", bus.ex_valid, vecs[i].exp_valid);
      chk("vec_regWrite", bus.ex_regWrite, vecs[i].exp_valid);
      chk("vec_memWrite", bus.ex_memWrite, vecs[i].exp_valid);
      chk("vec_aluOp", bus.ex_aluOp, 3'd5);
      chk("vec_stall", bus.stall, 1'b0);
    end

    // Load-use hazard: one bubble, then the dependent instruction loads
    load_lw(5'd7);
    c0 = int'(bus.bubble_cnt);
    idle_inputs();
    bus.id_valid = 1; bus.id_rs = 5'd7; bus.id_rt = 5'd2; bus.id_rd = 5'd3;
    bus.id_regDst = 1; bus.id_regWrite = 1; bus.id_rdata1 = 32'h70;
    #1 chk("lu_stall_hi", bus.stall, 1'b1);
    cycle();
    chk("lu_bubble_valid", bus.ex_valid, 1'b0);
    chk("lu_bubble_regWrite", bus.ex_regWrite, 1'b0);
    chk("lu_bubble_memRead", bus.ex_memRead, 1'b0);
    chk("lu_cnt", bus.bubble_cnt, 16'(c0 + 1));
    #1 chk("lu_stall_lo", bus.stall, 1'b0);
    cycle();
    chk("lu_load_valid", bus.ex_valid, 1'b1);
    chk("lu_load_rs", bus.ex_rs, 5'd7);
    chk("lu_load_dst", bus.ex_dst, 5'd3);

    // Hazard on rt side also stalls
    load_lw(5'd9);
    idle_inputs();
    bus.id_valid = 1; bus.id_rs = 5'd1; bus.id_rt = 5'd9;
    #1 chk("rt_stall", bus.stall, 1'b1);
    cycle();
    cycle();

    // Flush wins over hazard: no stall, exactly one bubble counted
    load_lw(5'd7);
    c0 = int'(bus.bubble_cnt);
    idle_inputs();
    bus.id_valid = 1; bus.id_rs = 5'd7; bus.flush = 1;
    #1 chk("fl_stall", bus.stall, 1'b0);
    cycle();
    chk("fl_valid", bus.ex_valid, 1'b0);
    chk("fl_cnt", bus.bubble_cnt, 16'(c0 + 1));

    // Load writing r0 is never a hazard
    load_lw(5'd0);
    c0 = int'(bus.bubble_cnt);
    idle_inputs();
    bus.id_valid = 1; bus.id_rs = 5'd0; bus.id_rt = 5'd0;
    #1 chk("r0_stall", bus.stall, 1'b0);
    cycle();
    chk("r0_valid", bus.ex_valid, 1'b1);
    chk("r0_cnt", bus.bubble_cnt, 16'(c0));

    // Empty ID slot with no flush does not count
    idle_inputs();
    c0 = int'(bus.bubble_cnt);
    cycle();
    chk("idle_cnt", bus.bubble_cnt, 16'(c0));

    // Reset in the middle of a stall, with flush also asserted
    load_lw(5'd7);
    idle_inputs();
    bus.id_valid = 1; bus.id_rs = 5'd7; bus.flush = 1;
    rst_n = 0;
    cycle();
    chk("rst_valid", bus.ex_valid, 1'b0);
    chk("rst_memRead", bus.ex_memRead, 1'b0);
    chk("rst_cnt", bus.bubble_cnt, 16'h0);
    chk("rst_stall", bus.stall, 1'b0);
    rst_n = 1;

    // Saturation: 2^16 + 3 flush bubbles from zero
    idle_inputs();
    bus.flush = 1;
    for (int i = 0; i < 65539; i++) cycle();
    chk("sat_cnt", bus.bubble_cnt, 16'hFFFF);
    bus.flush = 0;
    bus.id_valid = 1; bus.id_rs = 5'd3;
    cycle();
    chk("sat_hold", bus.bubble_cnt, 16'hFFFF);
    rst_n = 0;
    bus.flush = 1;
    cycle();
    chk("sat_rst_cnt", bus.bubble_cnt, 16'h0);
    chk("sat_rst_valid", bus.ex_valid, 1'b0);
    rst_n = 1;

    // Random stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      bus.id_valid    = ($urandom_range(0, 3) != 0);
      bus.id_pc       = $urandom;
      bus.id_imm      = $urandom;
      bus.id_rs       = 5'($urandom_range(0, 7));
      bus.id_rt       = 5'($urandom_range(0, 7));
      bus.id_rd       = 5'($urandom_range(0, 31));
      bus.id_rdata1   = $urandom;
      bus.id_rdata2   = $urandom;
      bus.id_regWrite = 1'($urandom);
      bus.id_memRead  = 1'($urandom);
      bus.id_memWrite = 1'($urandom);
      bus.id_aluSrc   = 1'($urandom);
      bus.id_regDst   = 1'($urandom);
      bus.id_aluOp    = 3'($urandom);
      bus.wb_write    = 1'($urandom);
      bus.wb_addr     = 5'($urandom_range(0, 7));
      bus.wb_data     = $urandom;
      bus.flush       = ($urandom_range(0, 7) == 0);
      rst_n           = ($urandom_range(0, 63) != 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
